// File: rtl/multicycle_ctrl_fsm_if.sv
// Bundle between the multi-cycle control sequencer and the datapath/memory.
// The sequencer takes the slave side; whatever drives the IR, the ALU flag
// and the memory port takes the master side.
interface multicycle_ctrl_fsm_if;
  logic [31:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic        reg_write;
  logic        mem_to_reg;
  logic        alu_src_b;
  logic [3:0]  alu_ctl;
  logic [1:0]  imm_sel;
  logic        retired;
  logic        error;
  logic [3:0]  state_o;

  modport master (
    output instruction, zero, mem_ready,
    input  mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
           alu_src_b, alu_ctl, imm_sel, retired, error, state_o
  );

  modport slave (
    input  instruction, zero, mem_ready,
    output mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
           alu_src_b, alu_ctl, imm_sel, retired, error, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Control sequencer for the multi-cycle RV64 datapath. Steps fetch, decode,
// execute, memory and writeback for R/I-ALU, ld, sd and beq/bne, and guards
// every memory wait with a watchdog that parks the machine in ERROR.
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_ctrl_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALU_WB = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WB = 4'd6,
    S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,
    S_ERROR  = 4'd15
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t          state, next;
  logic [TO_W-1:0] wd;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_store, mem_st, timeout;
  logic       unused_bits;

  assign opcode   = bus.instruction[6:0];
  assign funct3   = bus.instruction[14:12];
  assign is_r     = (opcode == OP_R);
  // Store and load opcodes differ only in bit 5; ADDR only sees those two.
  assign is_store = opcode[5];
  assign mem_st   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // Last permitted wait cycle; a ready on this same cycle still wins.
  assign timeout  = (wd == TO_W'(TIMEOUT - 1));
  assign unused_bits = ^{bus.instruction[31], bus.instruction[29:15], bus.instruction[11:7]};

  // State register and watchdog; any state change restarts the watchdog so
  // every memory state is entered with a zero count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      wd    <= '0;
    end else begin
      state <= next;
      if (next != state)
        wd <= '0;
      else if (mem_st && !bus.mem_ready)
        wd <= wd + 1'b1;
    end
  end

  // Next-state and Moore strobes; everything forced low while reset is held.
  always_comb begin
    next           = state;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_b  = 1'b0;
    bus.alu_ctl    = ALU_AND;
    bus.imm_sel    = 2'b00;
    bus.retired    = 1'b0;
    bus.error      = 1'b0;
    bus.state_o    = state;

    case (state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          next         = S_DECODE;
        end else if (timeout) begin
          next = S_ERROR;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R, OP_I:   next = S_EXEC;
          OP_LD, OP_SD: next = S_ADDR;
          OP_BR:        next = S_BRANCH;
          default:      next = S_ERROR;
        endcase
      end
      S_EXEC: begin
        bus.alu_src_b = !is_r;
        next          = S_ALU_WB;
        case (funct3)
          3'b000:  bus.alu_ctl = (is_r && bus.instruction[30]) ? ALU_SUB : ALU_ADD;
          3'b111:  bus.alu_ctl = ALU_AND;
          3'b110:  bus.alu_ctl = ALU_OR;
          default: next = S_ERROR;
        endcase
      end
      S_ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.pc_write  = 1'b1;
        bus.retired   = 1'b1;
        next          = S_FETCH;
      end
      S_ADDR: begin
        bus.alu_ctl   = ALU_ADD;
        bus.alu_src_b = 1'b1;
        bus.imm_sel   = is_store ? 2'b01 : 2'b00;
        if (funct3 != 3'b011) next = S_ERROR;
        else                  next = is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) next = S_MEM_WB;
        else if (timeout)  next = S_ERROR;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.pc_write   = 1'b1;
        bus.retired    = 1'b1;
        next           = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ready) begin
          bus.pc_write = 1'b1;
          bus.retired  = 1'b1;
          next         = S_FETCH;
        end else if (timeout) begin
          next = S_ERROR;
        end
      end
      S_BRANCH: begin
        bus.alu_ctl = ALU_SUB;
        bus.imm_sel = 2'b10;
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          bus.pc_write = 1'b1;
          bus.retired  = 1'b1;
          bus.pc_src   = funct3[0] ? !bus.zero : bus.zero;
          next         = S_FETCH;
        end else begin
          next = S_ERROR;
        end
      end
      S_ERROR: bus.error = 1'b1;
      default: next = S_ERROR;
    endcase

    if (reset) begin
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_b  = 1'b0;
      bus.alu_ctl    = 4'b0000;
      bus.imm_sel    = 2'b00;
      bus.retired    = 1'b0;
      bus.error      = 1'b0;
      bus.state_o    = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for the multi-cycle control sequencer. Each instruction is expanded
// into the per-cycle list of inputs and expected outputs it must produce,
// then replayed against the design while a negedge process compares.
module tb_multicycle_ctrl_fsm;
  localparam int TIMEOUT = 16;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if bus();

  multicycle_ctrl_fsm #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_we, ir_write, pc_write, pc_src;
    logic       reg_write, mem_to_reg, alu_src_b;
    logic [3:0] alu_ctl;
    logic [1:0] imm_sel;
    logic       retired, error;
  } outs_t;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        z;
    logic [31:0] ins;
    outs_t       o;
  } step_t;

  step_t       q[$];
  step_t       cur;
  bit          chk = 1'b0;
  logic [31:0] cur_ins = '0;
  int          tests = 0;
  int          fails = 0;

  function automatic outs_t blank(logic [3:0] st);
    outs_t o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic push(logic rst, logic rdy, logic z, outs_t o);
    step_t s;
    s.rst = rst; s.rdy = rdy; s.z = z; s.ins = cur_ins; s.o = o;
    q.push_back(s);
  endtask

  // Three parked cycles in ERROR (inputs ignored), then a reset cycle.
  task automatic err_tail();
    outs_t o;
    for (int i = 0; i < 3; i++) begin
      o = blank(4'd15);
      o.error = 1'b1;
      push(1'b0, 1'($urandom % 2), 1'($urandom % 2), o);
    end
    push(1'b1, 1'($urandom % 2), 1'b0, blank(4'd0));
  endtask

  // w cycles of request without ready; a timeout uses up TIMEOUT of them.
  task automatic mem_wait(logic [3:0] st, logic we, int w, output bit to);
    outs_t o;
    o = blank(st);
    o.mem_req = 1'b1;
    o.mem_we  = we;
    to = 1'b0;
    for (int k = 0; k < w; k++) begin
      push(1'b0, 1'b0, 1'($urandom % 2), o);
      if (k == TIMEOUT - 1) begin
        to = 1'b1;
        return;
      end
    end
  endtask

  // Expand one instruction into its expected cycles. abort_at >= 0 replaces
  // that cycle of the instruction with a reset cycle.
  task automatic build(logic [31:0] ins, int wf, int wm, logic zb, int abort_at);
    outs_t      o;
    bit         to, bad;
    logic [6:0] op;
    logic [2:0] f3;
    int         start;
    op = ins[6:0];
    f3 = ins[14:12];
    bad = 1'b0;
    start = q.size();
    cur_ins = ins;
    mem_wait(4'd0, 1'b0, wf, to);
    if (to) bad = 1'b1;
    else begin
      o = blank(4'd0); o.mem_req = 1'b1; o.ir_write = 1'b1;
      push(1'b0, 1'b1, 1'($urandom % 2), o);
      push(1'b0, 1'($urandom % 2), 1'($urandom % 2), blank(4'd1));
      if (op == OP_R || op == OP_I) begin
        o = blank(4'd2);
        o.alu_src_b = (op == OP_I);
        case (f3)
          3'd0:    o.alu_ctl = (op == OP_R && ins[30]) ? 4'b0110 : 4'b0010;
          3'd7:    o.alu_ctl = 4'b0000;
          3'd6:    o.alu_ctl = 4'b0001;
          default: bad = 1'b1;
        endcase
        push(1'b0, 1'($urandom % 2), 1'($urandom % 2), o);
        if (!bad) begin
          o = blank(4'd3); o.reg_write = 1'b1; o.pc_write = 1'b1; o.retired = 1'b1;
          push(1'b0, 1'($urandom % 2), 1'($urandom % 2), o);
        end
      end else if (op == OP_LD || op == OP_SD) begin
        o = blank(4'd4); o.alu_ctl = 4'b0010; o.alu_src_b = 1'b1;
        o.imm_sel = (op == OP_SD) ? 2'b01 : 2'b00;
        push(1'b0, 1'($urandom % 2), 1'($urandom % 2), o);
        if (f3 != 3'd3) bad = 1'b1;
        else if (op == OP_LD) begin
          mem_wait(4'd5, 1'b0, wm, to);
          if (to) bad = 1'b1;
          else begin
            o = blank(4'd5); o.mem_req = 1'b1;
            push(1'b0, 1'b1, 1'($urandom % 2), o);
            o = blank(4'd6); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
            o.pc_write = 1'b1; o.retired = 1'b1;
            push(1'b0, 1'($urandom % 2), 1'($urandom % 2), o);
          end
        end else begin
          mem_wait(4'd7, 1'b1, wm, to);
          if (to) bad = 1'b1;
          else begin
            o = blank(4'd7); o.mem_req = 1'b1; o.mem_we = 1'b1;
            o.pc_write = 1'b1; o.retired = 1'b1;
            push(1'b0, 1'b1, 1'($urandom % 2), o);
          end
        end
      end else if (op == OP_BR) begin
        o = blank(4'd8); o.alu_ctl = 4'b0110; o.imm_sel = 2'b10;
        if (f3 == 3'd0 || f3 == 3'd1) begin
          o.pc_write = 1'b1; o.retired = 1'b1;
          o.pc_src = (f3 == 3'd0) ? zb : !zb;
        end else bad = 1'b1;
        push(1'b0, 1'($urandom % 2), zb, o);
      end else bad = 1'b1;
    end
    if (abort_at >= 0 && abort_at < q.size() - start) begin
      while (q.size() > start + abort_at) void'(q.pop_back());
      push(1'b1, 1'($urandom % 2), 1'b0, blank(4'd0));
    end else if (bad) err_tail();
  endtask

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int count_state(logic [3:0] st);
    int n = 0;
    foreach (q[i]) if (q[i].o.st == st && !q[i].rst) n++;
    return n;
  endfunction

  function automatic int count_pcw();
    int n = 0;
    foreach (q[i]) if (q[i].o.pc_write) n++;
    return n;
  endfunction

  // Replay queued cycles back to back: inputs change 1 time unit after the edge.
  task automatic run_q();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(posedge clk);
      #1;
      reset           = s.rst;
      bus.mem_ready   = s.rdy;
      bus.zero        = s.z;
      bus.instruction = s.ins;
      cur             = s;
      chk             = 1'b1;
    end
  endtask

  // Compare every cycle's outputs against the expected record.
  always @(negedge clk) begin
    if (chk) begin
      outs_t a;
      a.st = bus.state_o; a.mem_req = bus.mem_req; a.mem_we = bus.mem_we;
      a.ir_write = bus.ir_write; a.pc_write = bus.pc_write; a.pc_src = bus.pc_src;
      a.reg_write = bus.reg_write; a.mem_to_reg = bus.mem_to_reg;
      a.alu_src_b = bus.alu_src_b; a.alu_ctl = bus.alu_ctl; a.imm_sel = bus.imm_sel;
      a.retired = bus.retired; a.error = bus.error;
      tests++;
      if (a !== cur.o) begin
        fails++;
        $display("FAIL cycle_outputs t=%0t ins=%h rst=%b rdy=%b z=%b got=%h expected=%h",
                 $time, cur.ins, cur.rst, cur.rdy, cur.z, a, cur.o);
      end
    end
  end

  function automatic logic [31:0] gen_ins();
    logic [31:0] r;
    logic [2:0]  f3;
    r = $urandom;
    case ($urandom % 6)
      0: begin
        f3 = ($urandom % 8 == 0) ? 3'($urandom) : ((($urandom % 3) == 0) ? 3'd0 : (($urandom % 2) ? 3'd6 : 3'd7));
        return {1'b0, 1'($urandom % 2), 5'd0, r[24:15], f3, r[11:7], OP_R};
      end
      1: begin
        f3 = ($urandom % 8 == 0) ? 3'($urandom) : ((($urandom % 3) == 0) ? 3'd0 : (($urandom % 2) ? 3'd6 : 3'd7));
        return {r[31:15], f3, r[11:7], OP_I};
      end
      2: return {r[31:15], ($urandom % 8 == 0) ? 3'($urandom) : 3'd3, r[11:7], OP_LD};
      3: return {r[31:15], ($urandom % 8 == 0) ? 3'($urandom) : 3'd3, r[11:7], OP_SD};
      4: return {r[31:15], ($urandom % 8 == 0) ? 3'($urandom) : 3'($urandom % 2), r[11:7], OP_BR};
      default: return r;
    endcase
  endfunction

  function automatic int gen_wait();
    return ($urandom % 10 == 0) ? 14 + int'($urandom % 4) : int'($urandom % 3);
  endfunction

  initial begin
    bus.instruction = '0;
    bus.mem_ready   = 1'b0;
    bus.zero        = 1'b0;

    push(1'b1, 1'b0, 1'b0, blank(4'd0));
    push(1'b1, 1'b1, 1'b1, blank(4'd0));
    run_q();

    build(32'h002081B3, 0, 0, 1'b0, -1);
    check("add_len", q.size(), 4);
    check("add_alu_ctl", q[2].o.alu_ctl, 2);
    check("add_retire_c4", q[3].o.retired & q[3].o.reg_write, 1);
    run_q();

    build(32'h0080B283, 0, 3, 1'b0, -1);
    check("ld_len", q.size(), 8);
    check("ld_memrd_cycles", count_state(4'd5), 4);
    check("ld_mem_to_reg", q[7].o.mem_to_reg, 1);
    run_q();

    build(32'h00208463, 0, 0, 1'b1, -1);
    check("beq_len", q.size(), 3);
    check("beq_taken_pc_src", q[2].o.pc_src, 1);
    check("beq_imm_sel", q[2].o.imm_sel, 2);
    run_q();
    build(32'h00208463, 0, 0, 1'b0, -1);
    check("beq_not_taken_pc_src", q[2].o.pc_src, 0);
    check("beq_alu_ctl", q[2].o.alu_ctl, 6);
    run_q();

    build(32'h0020B423, 0, 0, 1'b0, -1);
    check("sd_len", q.size(), 4);
    run_q();
    build(32'h0020B423, 0, 15, 1'b0, -1);
    check("sd_ready_on_last_wait_len", q.size(), 19);
    run_q();
    build(32'h0020B423, 0, 40, 1'b0, -1);
    check("sd_timeout_memwr_cycles", count_state(4'd7), 16);
    check("sd_timeout_no_pc_write", count_pcw(), 0);
    run_q();

    build(32'h0000007F, 0, 0, 1'b0, -1);
    check("illegal_len", q.size(), 6);
    run_q();
    build(32'h0000007F, 16, 0, 1'b0, -1);
    check("fetch_timeout_cycles", count_state(4'd0), 16);
    run_q();

    build(32'h0080B283, 0, 0, 1'b0, 4);
    check("abort_in_memwb_len", q.size(), 5);
    check("abort_is_reset", q[4].rst, 1);
    run_q();

    for (int n = 0; n < 300; n++) begin
      build(gen_ins(), gen_wait(), gen_wait(), 1'($urandom % 2),
            ($urandom % 15 == 0) ? int'($urandom % 6) : -1);
      run_q();
    end

    @(negedge clk);
    #2;
    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
